// File: rtl/t03_nes_poll_controller.sv
// t03_nes_poll_controller
// Autonomous NES pad poll engine. A free-running prescaler defines a tick grid.
// Each poll drives the shared latch/pulse strobes on that grid and samples both
// pad serial lines into private shift registers. It then commits the two
// button words to the consumer through a valid/ack handshake with a sticky
// overrun flag.
// Optional feature: define T03_NES_EDGE_EN to add per-commit rising-edge
// press flags (pressed_a/pressed_b). Without it those ports are tied to zero.
module t03_nes_poll_controller #(
    parameter int CLK_DIV     = 8,
    parameter int LATCH_TICKS = 3,
    parameter int PULSE_HI    = 1,
    parameter int PULSE_LO    = 1,
    parameter int POLL_PERIOD = 1000,
    parameter int NBITS       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             poll_now,
    input  logic             ser_a,
    input  logic             ser_b,
    output logic             latch,
    output logic             pulse,
    output logic             busy,
    output logic [NBITS-1:0] buttons_a,
    output logic [NBITS-1:0] buttons_b,
    output logic             data_valid,
    input  logic             data_ack,
    output logic             overrun,
    output logic [NBITS-1:0] pressed_a,
    output logic [NBITS-1:0] pressed_b
);

    localparam int PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_MAX = (LATCH_TICKS > PULSE_HI)
                             ? ((LATCH_TICKS > PULSE_LO) ? LATCH_TICKS : PULSE_LO)
                             : ((PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PER_W   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int BIT_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_PHI,
        S_PLO,
        S_COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               pending_q, pending_d;
    logic [NBITS-1:0]   sh_a_q, sh_a_d;
    logic [NBITS-1:0]   sh_b_q, sh_b_d;
    logic               latch_q, latch_d;
    logic               pulse_q, pulse_d;
    logic [NBITS-1:0]   btn_a_q, btn_a_d;
    logic [NBITS-1:0]   btn_b_q, btn_b_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               tick;
    logic               start;
    logic               commit;

`ifdef T03_NES_EDGE_EN
    logic [NBITS-1:0]   prs_a_q, prs_a_d;
    logic [NBITS-1:0]   prs_b_q, prs_b_d;
`endif

    assign tick = (presc_q == PRE_W'(CLK_DIV - 1));

    // Next-state logic: prescaler, poll scheduling, strobe sequencer, sampling and handshake
    always_comb begin
        state_d   = state_q;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        per_d     = per_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        latch_d   = latch_q;
        pulse_d   = pulse_q;
        btn_a_d   = btn_a_q;
        btn_b_d   = btn_b_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        commit    = 1'b0;

        // Period counter saturates so a long idle still triggers on the next tick
        if (tick && (per_q != PER_W'(POLL_PERIOD - 1))) begin
            per_d = per_q + 1'b1;
        end

        // A same-cycle poll_now counts as pending so a request on a tick is not delayed
        start     = tick && (state_q == S_IDLE) &&
                    (pending_q || poll_now ||
                     (enable && (per_q == PER_W'(POLL_PERIOD - 1))));
        pending_d = (pending_q | poll_now) & ~start;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LATCH;
                    latch_d = 1'b1;
                    cnt_d   = CNT_W'(LATCH_TICKS - 1);
                    per_d   = '0;
                    bit_d   = '0;
                    sh_a_d  = '0;
                    sh_b_d  = '0;
                end
            end
            S_LATCH: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        // Bit 0 is presented by the pad while latch is still high
                        sh_a_d[0] = ~ser_a;
                        sh_b_d[0] = ~ser_b;
                        bit_d     = '0;
                        state_d   = S_PHI;
                        latch_d   = 1'b0;
                        pulse_d   = 1'b1;
                        cnt_d     = CNT_W'(PULSE_HI - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_PHI: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = S_PLO;
                        pulse_d = 1'b0;
                        cnt_d   = CNT_W'(PULSE_LO - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_PLO: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        if (bit_q == BIT_W'(NBITS - 1)) begin
                            // All bits already captured; the final pulse just completes the frame
                            state_d = S_COMMIT;
                            commit  = 1'b1;
                        end else begin
                            bit_d          = bit_q + 1'b1;
                            sh_a_d[bit_d]  = ~ser_a;
                            sh_b_d[bit_d]  = ~ser_b;
                            state_d        = S_PHI;
                            pulse_d        = 1'b1;
                            cnt_d          = CNT_W'(PULSE_HI - 1);
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                latch_d = 1'b0;
                pulse_d = 1'b0;
            end
        endcase

        // Words are published on the edge entering COMMIT, so they are visible during COMMIT
        if (commit) begin
            btn_a_d = sh_a_d;
            btn_b_d = sh_b_d;
            valid_d = 1'b1;
            // An ack landing with the commit consumed the old word, so no overrun is recorded
            ovr_d   = (valid_q && data_ack) ? 1'b0 : (ovr_q | valid_q);
        end else if (data_ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

`ifdef T03_NES_EDGE_EN
    // Press flags compare the incoming word with the word it replaces
    always_comb begin
        prs_a_d = prs_a_q;
        prs_b_d = prs_b_q;
        if (commit) begin
            prs_a_d = sh_a_d & ~btn_a_q;
            prs_b_d = sh_b_d & ~btn_b_q;
        end
    end
`endif

    // State registers with synchronous active-low reset; a mid-poll reset drops strobes and partial data
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            per_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            pending_q <= 1'b0;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            btn_a_q   <= '0;
            btn_b_q   <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef T03_NES_EDGE_EN
            prs_a_q   <= '0;
            prs_b_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            pending_q <= pending_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            btn_a_q   <= btn_a_d;
            btn_b_q   <= btn_b_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
`ifdef T03_NES_EDGE_EN
            prs_a_q   <= prs_a_d;
            prs_b_q   <= prs_b_d;
`endif
        end
    end

    assign latch      = latch_q;
    assign pulse      = pulse_q;
    assign busy       = (state_q != S_IDLE);
    assign buttons_a  = btn_a_q;
    assign buttons_b  = btn_b_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;

`ifdef T03_NES_EDGE_EN
    assign pressed_a  = prs_a_q;
    assign pressed_b  = prs_b_q;
`else
    assign pressed_a  = '0;
    assign pressed_b  = '0;
`endif

endmodule
